// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants, state encoding and step function for the
//                12-bit x^12+x^6+x^4+x+1 LFSR random source.
//  Revision    : 1.0
// ============================================================================
package lfsr_pkg;

    localparam int unsigned c_WIDTH    = 12;
    localparam logic [11:0] c_SEED     = 12'h001;
    localparam logic [11:0] c_TAP_MASK = 12'h829;
    localparam int unsigned c_PERIOD   = 4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Fibonacci form, shift left, feedback enters at bit 0.
    function automatic logic [11:0] lfsr_next(input logic [11:0] s);
        return {s[10:0], ^(s & c_TAP_MASK)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_core
//  Description : LFSR state register with step, load and lock-up recovery.
//  Revision    : 1.0
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = c_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = c_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             at_seed
);

    logic [WIDTH-1:0] r_state;

    // All-zero is outside the sequence, so it is always replaced by SEED.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= load_val;
        end else if (r_state == '0) begin
            r_state <= SEED;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

    // High when a step taken now would land on SEED.
    assign at_seed = (lfsr_next(r_state) == SEED);

endmodule
`default_nettype wire

// File: rtl/lfsr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_arbiter
//  Description : Round-robin req/ack front end sharing one LFSR between
//                requesters, with reseeding, lock-up recovery and period check.
//  Revision    : 1.0
// ============================================================================
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned      N_REQ = 4,
    parameter int unsigned      WIDTH = c_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = c_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [WIDTH-1:0] rnd_data,
    input  logic             free_run,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic             wrap_tick,
    output logic             period_err,
    output logic             busy
);

    localparam int unsigned c_PTR_W      = (N_REQ > 2) ? 2 : 1;
    localparam logic [11:0] c_WRAP_COUNT = 12'(c_PERIOD - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_winner;
    logic [c_PTR_W-1:0] w_winner;
    logic [c_PTR_W-1:0] w_cand;
    int                 w_idx;
    logic               w_any_req;
    logic [WIDTH-1:0]   r_seed_val;
    logic [WIDTH-1:0]   w_seed_eff;
    logic [WIDTH-1:0]   r_rnd_hold;
    logic [WIDTH-1:0]   w_lfsr;
    logic               w_at_seed;
    logic [11:0]        r_count;
    logic               r_armed;
    logic               r_period_err;
    logic               w_idle;
    logic               w_load;
    logic               w_serve_ok;
    logic               w_lockup;
    logic               w_step;
    logic               w_wrap;

    // Walk from the farthest offset back to the pointer so the nearest wins.
    always_comb begin
        w_winner  = r_ptr;
        w_any_req = 1'b0;
        w_idx     = 0;
        w_cand    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= int'(N_REQ)) begin
                w_idx = w_idx - int'(N_REQ);
            end
            w_cand = c_PTR_W'(w_idx);
            if (req[w_cand]) begin
                w_winner  = w_cand;
                w_any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (seed_load) begin
                    w_state_next = ST_LOAD;
                end else if (w_any_req) begin
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: w_state_next = ST_IDLE;
            ST_LOAD:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign w_load     = (r_state == ST_LOAD);
    // A requester that dropped req before its ack cycle forfeits the grant.
    assign w_serve_ok = (r_state == ST_SERVE) && req[r_winner];
    assign w_seed_eff = (r_seed_val == '0) ? SEED : r_seed_val;
    assign w_lockup   = (w_lfsr == '0);
    assign w_step     = !w_lockup &&
                        (w_serve_ok || (w_idle && !seed_load && !w_any_req && free_run));
    assign w_wrap     = w_step && w_at_seed;

    always_comb begin
        busy     = !w_idle;
        rnd_data = w_serve_ok ? w_lfsr : r_rnd_hold;
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_ack
        assign ack[g] = w_serve_ok && (r_winner == c_PTR_W'(g));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_winner   <= '0;
            r_seed_val <= '0;
            r_rnd_hold <= '0;
        end else begin
            if (w_idle && seed_load) begin
                r_seed_val <= seed_val;
            end else if (w_idle && w_any_req) begin
                r_winner <= w_winner;
            end
            if (w_serve_ok) begin
                r_rnd_hold <= w_lfsr;
                r_ptr      <= (r_winner == c_PTR_W'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
            end
        end
    end

    // Checking stays disarmed after a load to a non-SEED value until the
    // sequence first comes back around to SEED.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_armed      <= 1'b1;
            r_period_err <= 1'b0;
        end else begin
            if (w_lockup) begin
                r_period_err <= 1'b1;
            end
            if (w_load) begin
                r_count <= '0;
                r_armed <= (w_seed_eff == SEED);
            end else if (w_wrap) begin
                r_count <= '0;
                r_armed <= 1'b1;
                if (r_armed && (r_count != c_WRAP_COUNT)) begin
                    r_period_err <= 1'b1;
                end
            end else if (w_step) begin
                r_count <= r_count + 12'd1;
            end
        end
    end

    assign wrap_tick  = w_wrap;
    assign period_err = r_period_err;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (w_step),
        .load     (w_load),
        .load_val (w_seed_eff),
        .state    (w_lfsr),
        .at_seed  (w_at_seed)
    );

endmodule
`default_nettype wire

// File: tb/tb_lfsr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_arbiter
//  Description : Self-checking bench for lfsr_arbiter: vector table plus
//                ack scoreboard and directed multi-cycle sequences.
//  Revision    : 1.0
// ============================================================================
module tb_lfsr_arbiter;

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [11:0] rnd;
    } vec_t;

    typedef struct packed {
        logic [3:0]  ack;
        logic [11:0] rnd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  ack;
    logic [11:0] rnd_data;
    logic        free_run = 1'b0;
    logic        seed_load = 1'b0;
    logic [11:0] seed_val = '0;
    logic        wrap_tick;
    logic        period_err;
    logic        busy;

    int   n_checks = 0;
    int   n_errs = 0;
    int   n_acks = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   ack_cyc[$];
    logic [11:0] got_rnd[$];

    lfsr_arbiter #(
        .N_REQ (4),
        .WIDTH (12),
        .SEED  (12'h001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .rnd_data   (rnd_data),
        .free_run   (free_run),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .wrap_tick  (wrap_tick),
        .period_err (period_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] model_step(input logic [11:0] s);
        return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        req       = '0;
        free_run  = 1'b0;
        seed_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (n_acks < target && c < budget);
        #1;
        if (n_acks < target) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s_timeout: got %0d acks, required %0d", name, n_acks, target);
        end
    endtask

    // Scoreboard side: every ack is popped against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && ack != '0) begin
                n_acks++;
                ack_cyc.push_back(cyc);
                got_rnd.push_back(rnd_data);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_ack: got ack=%b rnd=0x%0h, required no ack", ack, rnd_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_ack", {28'd0, ack}, {28'd0, e.ack});
                    chk("sb_rnd", {20'd0, rnd_data}, {20'd0, e.rnd});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[13];
        logic [11:0] s;
        int          c0;
        int          base;
        int          dup;
        int          wraps;
        int          wrap_at;
        int          n_expect;

        vecs[0] = '{req: 4'b0001, ack: 4'b0001, rnd: 12'h001};
        vecs[1] = '{req: 4'b0001, ack: 4'b0001, rnd: 12'h003};
        vecs[2] = '{req: 4'b0001, ack: 4'b0001, rnd: 12'h007};
        vecs[3] = '{req: 4'b0001, ack: 4'b0001, rnd: 12'h00F};
        vecs[4] = '{req: 4'b0001, ack: 4'b0001, rnd: 12'h01E};
        s = 12'h001;
        for (int i = 5; i < 13; i++) begin
            vecs[i].req = 4'b1111;
            vecs[i].ack = 4'b0001 << ((i - 5) % 4);
            vecs[i].rnd = s;
            s = model_step(s);
        end

        // Reset state
        apply_reset();
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_rnd", {20'd0, rnd_data}, 32'd0);
        chk("rst_wrap", {31'd0, wrap_tick}, 32'd0);
        chk("rst_err", {31'd0, period_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_lfsr", {20'd0, dut.u_core.state}, 32'h001);
        chk("rst_ptr", {30'd0, dut.r_ptr}, 32'd0);

        // Single requester held: sequence, latency and 2-cycle spacing
        ack_cyc.delete();
        base  = n_acks;
        req   = vecs[0].req;
        reset = 1'b1;
        c0    = cyc;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{ack: vecs[i].ack, rnd: vecs[i].rnd});
            req = vecs[i].req;
            wait_acks(base + i + 1, 6, "single");
        end
        req = '0;
        if (ack_cyc.size() == 5) begin
            chk("ack_latency", ack_cyc[0], c0 + 1);
            for (int i = 1; i < 5; i++) chk("ack_gap", ack_cyc[i] - ack_cyc[i-1], 32'd2);
        end else begin
            chk("single_ack_count", ack_cyc.size(), 32'd5);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rnd_hold", {20'd0, rnd_data}, 32'h01E);
        chk("idle_ack", {28'd0, ack}, 32'd0);

        // All four requesting from reset: round-robin order, distinct words
        apply_reset();
        got_rnd.delete();
        base  = n_acks;
        req   = 4'b1111;
        reset = 1'b1;
        for (int i = 5; i < 13; i++) begin
            sb_q.push_back('{ack: vecs[i].ack, rnd: vecs[i].rnd});
            req = vecs[i].req;
            wait_acks(base + i - 4, 6, "rr");
        end
        req = '0;
        dup = 0;
        for (int a = 0; a < got_rnd.size(); a++)
            for (int b = a + 1; b < got_rnd.size(); b++)
                if (got_rnd[a] == got_rnd[b]) dup++;
        chk("rr_count", got_rnd.size(), 32'd8);
        chk("rr_distinct", dup, 32'd0);

        // Free-running full period from reset
        apply_reset();
        free_run = 1'b1;
        reset    = 1'b1;
        wraps    = 0;
        wrap_at  = -1;
        for (int k = 1; k <= 4100; k++) begin
            @(negedge clk);
            if (wrap_tick) begin
                wraps++;
                if (wrap_at < 0) wrap_at = k;
            end
        end
        @(posedge clk);
        #1;
        free_run = 1'b0;
        chk("fr_wrap_count", wraps, 32'd1);
        chk("fr_wrap_cycle", wrap_at, 32'd4095);
        chk("fr_period_err", {31'd0, period_err}, 32'd0);

        // seed_load of zero together with req[2]: LOAD first, then grant
        base      = n_acks;
        seed_load = 1'b1;
        seed_val  = 12'h000;
        req       = 4'b0100;
        sb_q.push_back('{ack: 4'b0100, rnd: 12'h001});
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        @(negedge clk);
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ack", {28'd0, ack}, 32'd0);
        wait_acks(base + 1, 6, "load_req");
        req = '0;
        chk("load_err", {31'd0, period_err}, 32'd0);

        // Load a non-SEED value: first wrap is not a period violation
        s        = 12'h5A5;
        n_expect = 0;
        do begin
            s = model_step(s);
            n_expect++;
        end while (s != 12'h001 && n_expect < 5000);
        seed_load = 1'b1;
        seed_val  = 12'h5A5;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        free_run  = 1'b1;
        @(posedge clk);
        #1;
        chk("seed_loaded", {20'd0, dut.u_core.state}, 32'h5A5);
        wrap_at = -1;
        for (int k = 1; k <= 4200; k++) begin
            @(negedge clk);
            if (wrap_tick) begin
                wrap_at = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        free_run = 1'b0;
        chk("susp_wrap_cycle", wrap_at, n_expect);
        chk("susp_err", {31'd0, period_err}, 32'd0);

        // Lock-up: zero state recovers to SEED and raises sticky error
        force dut.u_core.r_state = 12'h000;
        #1;
        release dut.u_core.r_state;
        @(posedge clk);
        #1;
        chk("lock_recover", {20'd0, dut.u_core.state}, 32'h001);
        chk("lock_err", {31'd0, period_err}, 32'd1);
        seed_load = 1'b1;
        seed_val  = 12'h001;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lock_err_sticky", {31'd0, period_err}, 32'd1);
        apply_reset();
        chk("lock_err_cleared", {31'd0, period_err}, 32'd0);

        // Reset during SERVE aborts the grant
        req   = 4'b0001;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("serve_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_ack", {28'd0, ack}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rnd", {20'd0, rnd_data}, 32'd0);
        @(posedge clk);
        #1;
        base  = n_acks;
        reset = 1'b1;
        sb_q.push_back('{ack: 4'b0001, rnd: 12'h001});
        wait_acks(base + 1, 6, "after_abort");
        req = '0;

        // Requester drops before its ack cycle: no ack issued
        req = 4'b0010;
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        chk("drop_ack", {28'd0, ack}, 32'd0);
        chk("drop_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Shares one 12-bit maximal-length LFSR random source between up to four requesters. Round-robin arbitration and a req/ack handshake deliver one unique random word per grant. The block also handles seeding, lock-up recovery and period checking, and sits between the free-running LFSR datapath and its consumers (display, test-pattern and game logic). It runs on the system clock, not the divided display clock.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..4)
- WIDTH, 12, LFSR width; fixed at 12 for this polynomial
- SEED, 12'h001, reset and fallback seed; must be non-zero

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester; held high until matching ack
- ack  out  N_REQ  one-cycle grant pulse, one-hot
- rnd_data  out  WIDTH  random word; valid in the ack cycle, held until the next ack
- free_run  in  1  when 1, LFSR also steps every IDLE cycle with no grant
- seed_load  in  1  reseed request, sampled in IDLE
- seed_val  in  WIDTH  seed value for seed_load
- wrap_tick  out  1  one-cycle pulse when the LFSR state returns to SEED
- period_err  out  1  sticky error flag, cleared only by reset
- busy  out  1  high in SERVE or LOAD

## Operation
- LFSR: Fibonacci, shift left.
  - next = {s[10:0], s[11]^s[5]^s[3]^s[0]} (x^12+x^6+x^4+x+1).
  - Period is 4095; the all-zero state is excluded.
- States: IDLE, SERVE, LOAD. Reset enters IDLE with the LFSR state = SEED.
- IDLE, in priority order:
  - seed_load=1 -> LOAD.
  - Otherwise any req -> latch the round-robin winner -> SERVE.
  - Otherwise step the LFSR if free_run=1.
- SERVE:
  - rnd_data <= current LFSR state.
  - ack[winner] = 1.
  - LFSR steps once.
  - Round-robin pointer <= winner+1 mod N_REQ.
  - -> IDLE.
- LOAD:
  - LFSR <= seed_val, or SEED if seed_val == 0 (period_err unaffected).
  - Period counter cleared.
  - -> IDLE.
- Round-robin: search starts at the pointer index. The pointer resets to 0, so req[0] wins first. After requester k is granted, k has the lowest priority.
- Period counter: 12-bit, increments on every LFSR step.
  - When a step lands on SEED: pulse wrap_tick and clear the counter.
  - If that step's count != 4094, set period_err.
- Lock-up: if the LFSR state is ever 0 (fault), force it to SEED on the next cycle and set period_err.
- Period checking is suspended until the first wrap after a LOAD to a non-SEED value. The counter is re-armed on that wrap.

## Timing
- Reset values: ack=0, rnd_data=0, wrap_tick=0, period_err=0, busy=0, pointer=0, LFSR=SEED.
- Latency: req rising in cycle n (state IDLE) -> ack in cycle n+1.
- Maximum throughput is one grant every 2 cycles.
- req must stay high through its ack cycle. A requester deasserting before ack loses its slot, and no ack is issued to it.
- A requester that re-asserts immediately waits behind the other pending requesters.
- seed_load and req in the same IDLE cycle: LOAD wins, and requests are served after return to IDLE.
- seed_load asserted outside IDLE is ignored. It must be held until busy=0.
- wrap_tick in SERVE coincides with the ack cycle. The rnd_data delivered in that cycle is the pre-step value.
- Reset mid-SERVE aborts: no ack, state IDLE, LFSR=SEED.

## Structure
- Package lfsr_pkg:
  - WIDTH, SEED and the tap mask 12'h829.
  - PERIOD = 4095.
  - State enum {IDLE, SERVE, LOAD}.
- Sub-module lfsr_core holds the LFSR register. It has:
  - Inputs: step, load, load_val.
  - Outputs: state, at_seed.
- The arbiter, FSM and period checker live in lfsr_arbiter.

## Test plan
- Reset, then hold req=4'b0001 with free_run=0 -> successive acks return rnd_data 0x001, 0x003, 0x007, 0x00F, 0x01E; each ack follows 2 cycles after the previous one.
- Hold req=4'b1111 for 8 grants from reset -> ack order 0,1,2,3,0,1,2,3; all delivered words are distinct.
- Set free_run=1, no requests, for 4095 cycles -> exactly one wrap_tick at cycle 4095 after reset; period_err stays 0.
- Pulse seed_load with seed_val=0x000 and req[2] in the same cycle -> LOAD first, LFSR=0x001, then ack[2] with rnd_data 0x001.
- Force the lfsr_core state to 0 -> state becomes SEED the next cycle and period_err=1 until reset.
- Assert reset during SERVE -> ack stays 0, busy=0 and rnd_data=0 immediately; the next grant returns 0x001.
